instr_encoder_loader: RTL

- Builds RV32I instruction words from decoded fields: format, opcode, funct3, funct7, rd, rs1, rs2 and immediate.
- It is the encoding counterpart of the core's instruction decode path.
- Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a write handshake.
- Used by the test harness and boot logic to load programs into instruction memory before or alongside core execution.

---
 rtl/instr_encoder_loader_if.sv | 36 +++
 rtl/instr_encoder_loader.sv | 110 +++++++++++
 2 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request and memory-write signal bundle for the instruction encoder/loader.
// The master side issues encode requests and acknowledges memory writes.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_fmt;
  logic [6:0]        req_opcode;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output req_valid, req_fmt, req_opcode, req_funct3,
    output req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );

  modport slave (
    input  req_valid, req_fmt, req_opcode, req_funct3,
    input  req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder feeding a small FIFO that streams words
// into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  instr_encoder_loader_if.slave        bus,
  output logic [15:0]                  words_written,
  output logic                         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  logic [31:0]       fifo [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              bad;
  logic              acc;
  logic              push;
  logic              pop;

  logic [31:0] imm;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign imm = bus.req_imm;
  assign op  = bus.req_opcode;
  assign f3  = bus.req_funct3;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    unique case (1'b1)
      bus.req_fmt == F_R:
        word = {bus.req_funct7, rs2, rs1, f3, rd, op};
      bus.req_fmt == F_I:
        word = {imm[11:0], rs1, f3, rd, op};
      bus.req_fmt == F_S:
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      bus.req_fmt == F_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], op};
        bad  = imm[0];
      end
      bus.req_fmt == F_U:
        word = {imm[31:12], rd, op};
      bus.req_fmt == F_J: begin
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, op};
        bad  = imm[0];
      end
      default: bad = 1'b1;
    endcase
  end

  // Bad requests still complete the handshake; they only raise err.
  assign bus.req_ready = count < FULL;
  assign acc           = bus.req_valid & bus.req_ready;
  assign push          = acc & ~bad;
  assign pop           = bus.mem_we & bus.mem_ready;

  assign bus.mem_we    = count != '0;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = bus.mem_we ? fifo[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      addr          <= BASE_ADDR;
      words_written <= '0;
      err           <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        addr          <= addr + ADDR_W'(4);
        words_written <= words_written + 16'd1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      err   <= err | (acc & bad);
    end
  end

endmodule
